// File: rtl/spram_burst_ctrl.sv
// rtl/spram_burst_ctrl.sv - burst request controller for a single-port RAM with a shared data bus
module spram_burst_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter int ADDR  = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic             i_req_wr,
    input  logic [ADDR-1:0]  i_req_addr,
    input  logic [ADDR-1:0]  i_req_len,
    input  logic             i_wdata_valid,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_wdata_ready,
    output logic             o_rdata_valid,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_rdata_last,
    output logic             o_done,
    output logic             o_busy,
    output logic             o_ram_cs,
    output logic             o_ram_wr,
    output logic [ADDR-1:0]  o_ram_addr,
    inout  wire  [WIDTH-1:0] io_ram_data
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_WDRAIN = 3'd2,
        S_READ   = 3'd3,
        S_RDRAIN = 3'd4
    } state_t;

    localparam logic [ADDR-1:0] ONE       = ADDR'(1);
    localparam logic [ADDR-1:0] ADDR_MASK = ADDR'(DEPTH - 1);

    // FSM state and burst bookkeeping
    state_t           r_state;
    logic [ADDR-1:0]  r_cur_addr;
    logic [ADDR-1:0]  r_beats_left;

    // Registered RAM-side signals; r_ram_last tags the final read beat in flight
    logic             r_ram_cs;
    logic             r_ram_wr;
    logic [ADDR-1:0]  r_ram_addr;
    logic             r_ram_last;
    logic [WIDTH-1:0] r_wdata_q;

    // Read return and completion
    logic [WIDTH-1:0] r_rdata;
    logic             r_rdata_valid;
    logic             r_rdata_last;
    logic             r_done;

    // Next-state values
    state_t           w_state_nxt;
    logic [ADDR-1:0]  w_cur_addr_nxt;
    logic [ADDR-1:0]  w_beats_left_nxt;
    logic             w_ram_cs_nxt;
    logic             w_ram_wr_nxt;
    logic [ADDR-1:0]  w_ram_addr_nxt;
    logic             w_ram_last_nxt;
    logic [WIDTH-1:0] w_wdata_q_nxt;
    logic             w_done_nxt;
    logic             w_req_ready;
    logic             w_wdata_ready;
    logic             w_capture;
    logic [ADDR-1:0]  w_addr_inc;
    logic             w_last_beat;

    // Address advances modulo DEPTH so bursts wrap past the top of the RAM
    assign w_addr_inc  = (r_cur_addr + ONE) & ADDR_MASK;
    assign w_last_beat = (r_beats_left == '0);

    // A read beat issued last cycle has its data on the bus now
    assign w_capture = r_ram_cs && !r_ram_wr;

    // State register; reset abandons any burst in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, handshake and RAM command decode
    always_comb begin
        w_state_nxt      = r_state;
        w_cur_addr_nxt   = r_cur_addr;
        w_beats_left_nxt = r_beats_left;
        w_ram_cs_nxt     = 1'b0;
        w_ram_wr_nxt     = 1'b0;
        w_ram_addr_nxt   = '0;
        w_ram_last_nxt   = 1'b0;
        w_wdata_q_nxt    = r_wdata_q;
        w_done_nxt       = 1'b0;
        w_req_ready      = 1'b0;
        w_wdata_ready    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_cur_addr_nxt   = i_req_addr;
                    w_beats_left_nxt = i_req_len;
                    w_state_nxt      = i_req_wr ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                w_wdata_ready = 1'b1;
                if (i_wdata_valid) begin
                    w_ram_cs_nxt     = 1'b1;
                    w_ram_wr_nxt     = 1'b1;
                    w_ram_addr_nxt   = r_cur_addr;
                    w_wdata_q_nxt    = i_wdata;
                    w_cur_addr_nxt   = w_addr_inc;
                    w_beats_left_nxt = r_beats_left - ONE;
                    if (w_last_beat) begin
                        w_state_nxt = S_WDRAIN;
                    end
                end
            end
            S_WDRAIN: begin
                // Last write beat commits at this state's closing edge
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_READ: begin
                w_ram_cs_nxt     = 1'b1;
                w_ram_addr_nxt   = r_cur_addr;
                w_ram_last_nxt   = w_last_beat;
                w_cur_addr_nxt   = w_addr_inc;
                w_beats_left_nxt = r_beats_left - ONE;
                if (w_last_beat) begin
                    w_state_nxt = S_RDRAIN;
                end
            end
            S_RDRAIN: begin
                // Final read capture happens at this state's closing edge
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_capture && r_ram_last) begin
            w_done_nxt = 1'b1;
        end
    end

    // Burst counters and registered RAM command
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cur_addr   <= '0;
            r_beats_left <= '0;
            r_ram_cs     <= 1'b0;
            r_ram_wr     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_last   <= 1'b0;
            r_wdata_q    <= '0;
            r_done       <= 1'b0;
        end else begin
            r_cur_addr   <= w_cur_addr_nxt;
            r_beats_left <= w_beats_left_nxt;
            r_ram_cs     <= w_ram_cs_nxt;
            r_ram_wr     <= w_ram_wr_nxt;
            r_ram_addr   <= w_ram_addr_nxt;
            r_ram_last   <= w_ram_last_nxt;
            r_wdata_q    <= w_wdata_q_nxt;
            r_done       <= w_done_nxt;
        end
    end

    // Sample the RAM's read data into a one-cycle-valid return beat
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_rdata_last  <= 1'b0;
        end else begin
            r_rdata_valid <= w_capture;
            r_rdata_last  <= w_capture && r_ram_last;
            if (w_capture) begin
                r_rdata <= io_ram_data;
            end
        end
    end

    // Controller owns the bus only during a registered write cycle
    assign io_ram_data = (r_ram_cs && r_ram_wr) ? r_wdata_q : {WIDTH{1'bz}};

    assign o_req_ready   = w_req_ready;
    assign o_wdata_ready = w_wdata_ready;
    assign o_busy        = (r_state != S_IDLE);
    assign o_ram_cs      = r_ram_cs;
    assign o_ram_wr      = r_ram_wr;
    assign o_ram_addr    = r_ram_addr;
    assign o_rdata       = r_rdata;
    assign o_rdata_valid = r_rdata_valid;
    assign o_rdata_last  = r_rdata_last;
    assign o_done        = r_done;

endmodule

// File: tb/tb_spram_burst_ctrl.sv
// tb/tb_spram_burst_ctrl.sv - self-checking bench for spram_burst_ctrl with a 64x8 RAM model
module tb_spram_burst_ctrl;

    typedef struct {
        int         cyc;
        logic       wr;
        logic [5:0] addr;
        logic [7:0] data;
    } ram_ev_t;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       last;
    } rd_ev_t;

    logic       clk;
    logic       rstn;
    logic       i_req_valid;
    logic       o_req_ready;
    logic       i_req_wr;
    logic [5:0] i_req_addr;
    logic [5:0] i_req_len;
    logic       i_wdata_valid;
    logic [7:0] i_wdata;
    logic       o_wdata_ready;
    logic       o_rdata_valid;
    logic [7:0] o_rdata;
    logic       o_rdata_last;
    logic       o_done;
    logic       o_busy;
    logic       o_ram_cs;
    logic       o_ram_wr;
    logic [5:0] o_ram_addr;
    wire  [7:0] ram_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int d0;

    logic [7:0] ram_mem   [64] = '{default: 8'h00};
    logic [7:0] mem_model [64] = '{default: 8'h00};

    ram_ev_t    exp_ram [$];
    rd_ev_t     exp_rd  [$];
    int         exp_done[$];
    ram_ev_t    rev;
    rd_ev_t     dev;
    logic [7:0] wq      [$];
    int         obs_addr[$];
    int         obs_rd  [$];

    int wrap_addr [4] = '{62, 63, 0, 1};
    int wrap_dat  [4] = '{'h11, 'h22, 'h33, 'h44};
    int gap_dat   [3] = '{'h5A, 'hC3, 'h7E};
    int rst_dat   [3] = '{'h91, 'h92, 'h16};

    spram_burst_ctrl dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_wr      (i_req_wr),
        .i_req_addr    (i_req_addr),
        .i_req_len     (i_req_len),
        .i_wdata_valid (i_wdata_valid),
        .i_wdata       (i_wdata),
        .o_wdata_ready (o_wdata_ready),
        .o_rdata_valid (o_rdata_valid),
        .o_rdata       (o_rdata),
        .o_rdata_last  (o_rdata_last),
        .o_done        (o_done),
        .o_busy        (o_busy),
        .o_ram_cs      (o_ram_cs),
        .o_ram_wr      (o_ram_wr),
        .o_ram_addr    (o_ram_addr),
        .io_ram_data   (ram_data)
    );

    // 64x8 RAM: combinational read onto the bus, synchronous write from the bus
    assign ram_data = (o_ram_cs && !o_ram_wr) ? ram_mem[o_ram_addr] : 8'bz;

    always @(posedge clk) begin
        if (o_ram_cs && o_ram_wr) ram_mem[o_ram_addr] <= ram_data;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!o_req_ready && t < 200) begin
            step();
            t++;
        end
        chk("req_ready_wait", 32'(o_req_ready), 1);
    endtask

    // Write burst of the bytes in wq starting at a, with gap idle cycles before each later beat
    task automatic write_burst(input logic [5:0] a, input int gap);
        int         n;
        logic [5:0] ad;
        n = wq.size();
        wait_ready();
        i_req_valid = 1'b1;
        i_req_wr    = 1'b1;
        i_req_addr  = a;
        i_req_len   = 6'(n - 1);
        step();
        i_req_valid = 1'b0;
        chk("req_ready_in_burst", 32'(o_req_ready), 0);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    i_wdata_valid = 1'b0;
                    step();
                end
            end
            ad            = 6'(int'(a) + i);
            i_wdata_valid = 1'b1;
            i_wdata       = wq[i];
            chk("wdata_ready", 32'(o_wdata_ready), 1);
            exp_ram.push_back(ram_ev_t'{cyc + 1, 1'b1, ad, wq[i]});
            mem_model[ad] = wq[i];
            step();
        end
        i_wdata_valid = 1'b0;
        chk("wdata_ready_drain", 32'(o_wdata_ready), 0);
        exp_done.push_back(cyc + 1);
        step();
        chk("req_ready_after_write", 32'(o_req_ready), 1);
        step();
        wq.delete();
    endtask

    // Read burst of n beats starting at a; expectations come from the shadow memory
    task automatic read_burst(input logic [5:0] a, input int n);
        int         c;
        logic [5:0] ad;
        wait_ready();
        c = cyc;
        i_req_valid = 1'b1;
        i_req_wr    = 1'b0;
        i_req_addr  = a;
        i_req_len   = 6'(n - 1);
        for (int i = 0; i < n; i++) begin
            ad = 6'(int'(a) + i);
            exp_ram.push_back(ram_ev_t'{c + 2 + i, 1'b0, ad, mem_model[ad]});
            exp_rd.push_back(rd_ev_t'{c + 3 + i, mem_model[ad], (i == n - 1)});
        end
        exp_done.push_back(c + 2 + n);
        step();
        i_req_valid = 1'b0;
        chk("req_ready_in_read", 32'(o_req_ready), 0);
        repeat (n + 1) step();
        chk("req_ready_after_read", 32'(o_req_ready), 1);
        step();
    endtask

    // Per-cycle comparison of every DUT output against the expected event schedule
    always @(negedge clk) begin
        if (rstn) begin
            while (exp_ram.size() > 0 && exp_ram[0].cyc < cyc) begin
                chk("ram_beat_missing", 32'(cyc), 32'(exp_ram[0].cyc));
                void'(exp_ram.pop_front());
            end
            if (exp_ram.size() > 0 && exp_ram[0].cyc == cyc) begin
                rev = exp_ram.pop_front();
                chk("ram_cs", 32'(o_ram_cs), 1);
                chk("ram_wr", 32'(o_ram_wr), 32'(rev.wr));
                chk("ram_addr", 32'(o_ram_addr), 32'(rev.addr));
                chk("ram_bus", 32'(ram_data), 32'(rev.data));
            end else begin
                chk("ram_cs_idle", 32'(o_ram_cs), 0);
                chk("ram_wr_idle", 32'(o_ram_wr), 0);
            end

            while (exp_rd.size() > 0 && exp_rd[0].cyc < cyc) begin
                chk("rdata_missing", 32'(cyc), 32'(exp_rd[0].cyc));
                void'(exp_rd.pop_front());
            end
            if (exp_rd.size() > 0 && exp_rd[0].cyc == cyc) begin
                dev = exp_rd.pop_front();
                chk("rdata_valid", 32'(o_rdata_valid), 1);
                chk("rdata", 32'(o_rdata), 32'(dev.data));
                chk("rdata_last", 32'(o_rdata_last), 32'(dev.last));
            end else begin
                chk("rdata_valid_idle", 32'(o_rdata_valid), 0);
                chk("rdata_last_idle", 32'(o_rdata_last), 0);
            end

            while (exp_done.size() > 0 && exp_done[0] < cyc) begin
                chk("done_missing", 32'(cyc), 32'(exp_done[0]));
                void'(exp_done.pop_front());
            end
            if (exp_done.size() > 0 && exp_done[0] == cyc) begin
                void'(exp_done.pop_front());
                chk("done", 32'(o_done), 1);
            end else begin
                chk("done_idle", 32'(o_done), 0);
            end

            chk("busy_vs_ready", 32'(o_busy), 32'(!o_req_ready));

            if (o_done) done_cnt++;
            if (o_ram_cs) obs_addr.push_back(int'(o_ram_addr));
            if (o_rdata_valid) obs_rd.push_back(int'(o_rdata));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn          = 1'b0;
        i_req_valid   = 1'b0;
        i_req_wr      = 1'b0;
        i_req_addr    = '0;
        i_req_len     = '0;
        i_wdata_valid = 1'b0;
        i_wdata       = '0;

        // Reset state
        #23;
        chk("rst_ram_cs", 32'(o_ram_cs), 0);
        chk("rst_ram_wr", 32'(o_ram_wr), 0);
        chk("rst_rdata_valid", 32'(o_rdata_valid), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_busy", 32'(o_busy), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("rst_req_ready", 32'(o_req_ready), 1);
        step();

        // Single beat write then read
        obs_addr.delete();
        wq = '{8'hA5};
        write_burst(6'd3, 0);
        chk("single_wr_cycles", 32'(obs_addr.size()), 1);
        chk("single_wr_addr", 32'(obs_addr[0]), 3);
        obs_addr.delete();
        obs_rd.delete();
        read_burst(6'd3, 1);
        chk("single_rd_cycles", 32'(obs_addr.size()), 1);
        chk("single_rd_beats", 32'(obs_rd.size()), 1);
        chk("single_rd_data", 32'(obs_rd[0]), 'hA5);

        // Wrap past the top address
        obs_addr.delete();
        wq = '{8'h11, 8'h22, 8'h33, 8'h44};
        write_burst(6'd62, 0);
        chk("wrap_wr_cycles", 32'(obs_addr.size()), 4);
        for (int i = 0; i < 4; i++) chk("wrap_wr_addr", 32'(obs_addr[i]), 32'(wrap_addr[i]));
        obs_rd.delete();
        read_burst(6'd62, 4);
        chk("wrap_rd_beats", 32'(obs_rd.size()), 4);
        for (int i = 0; i < 4; i++) chk("wrap_rd_data", 32'(obs_rd[i]), 32'(wrap_dat[i]));

        // Write with two idle cycles between beats
        d0 = done_cnt;
        wq = '{8'h5A, 8'hC3, 8'h7E};
        write_burst(6'd40, 2);
        chk("gap_done_once", 32'(done_cnt - d0), 1);
        obs_rd.delete();
        read_burst(6'd40, 3);
        for (int i = 0; i < 3; i++) chk("gap_rd_data", 32'(obs_rd[i]), 32'(gap_dat[i]));

        // Full depth write of address-valued data, then full read
        for (int i = 0; i < 64; i++) wq.push_back(8'(i));
        write_burst(6'd0, 0);
        obs_rd.delete();
        read_burst(6'd0, 64);
        chk("full_rd_beats", 32'(obs_rd.size()), 64);
        for (int i = 0; i < 64; i++) begin
            chk("full_rd_data", (i < obs_rd.size()) ? 32'(obs_rd[i]) : 32'hFFFF, 32'(i));
        end

        // Reset in the middle of an 8-beat write after two committed beats
        d0 = done_cnt;
        wait_ready();
        i_req_valid = 1'b1;
        i_req_wr    = 1'b1;
        i_req_addr  = 6'd20;
        i_req_len   = 6'd7;
        step();
        i_req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            i_wdata_valid = 1'b1;
            i_wdata       = 8'(8'h91 + i);
            exp_ram.push_back(ram_ev_t'{cyc + 1, 1'b1, 6'(20 + i), 8'(8'h91 + i)});
            mem_model[20 + i] = 8'(8'h91 + i);
            step();
        end
        i_wdata_valid = 1'b0;
        step();
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_ram_cs", 32'(o_ram_cs), 0);
        chk("midrst_ram_wr", 32'(o_ram_wr), 0);
        chk("midrst_busy", 32'(o_busy), 0);
        chk("midrst_done", 32'(o_done), 0);
        chk("midrst_wdata_ready", 32'(o_wdata_ready), 0);
        exp_ram.delete();
        exp_rd.delete();
        exp_done.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("midrst_req_ready", 32'(o_req_ready), 1);
        step();
        step();
        chk("midrst_no_done", 32'(done_cnt - d0), 0);
        obs_rd.delete();
        read_burst(6'd20, 3);
        chk("midrst_rd_beats", 32'(obs_rd.size()), 3);
        for (int i = 0; i < 3; i++) chk("midrst_rd_data", 32'(obs_rd[i]), 32'(rst_dat[i]));

        repeat (3) step();
        chk("end_queues_empty", 32'(exp_ram.size() + exp_rd.size() + exp_done.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
